// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the key-entry controller and the sequential divider.
// The master issues operands with start; the slave returns busy, done and the held results.
interface seq_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock: done DW cycles after start (1 cycle on divide-by-zero).
// Start is only taken in IDLE; requests while busy are dropped, results hold until the next completion.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider_if.slave   io
);
    localparam int            CW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nxt;

    // working registers; the shift register trades dividend bits for quotient bits
    logic [DW-1:0] shreg;
    logic [VW-1:0] dvs;
    logic [VW-1:0] rem_w;
    logic [CW-1:0] cnt;
    logic          zdiv;

    logic [DW-1:0] q_out;
    logic [VW-1:0] r_out;
    logic          dbz_out;

    logic [VW:0]   trial;
    logic [VW-1:0] diff;
    logic          fit;
    logic [VW-1:0] rem_nxt;
    logic [DW-1:0] shreg_nxt;
    logic          accept;
    logic          last;

    always_comb begin
        trial     = {rem_w, shreg[DW-1]};
        fit       = (trial >= {1'b0, dvs});
        // when fit holds the difference is below dvs, so VW bits suffice
        diff      = trial[VW-1:0] - dvs;
        rem_nxt   = fit ? diff : trial[VW-1:0];
        shreg_nxt = {shreg[DW-2:0], fit};
    end

    assign accept = (state == IDLE) && io.start;
    assign last   = (state == CALC) && (zdiv || (cnt == LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.start) state_nxt = CALC;
            CALC:    if (last)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            dvs   <= '0;
            rem_w <= '0;
            cnt   <= '0;
            zdiv  <= 1'b0;
        end else if (accept) begin
            shreg <= io.dividend;
            dvs   <= io.divisor;
            rem_w <= '0;
            cnt   <= '0;
            zdiv  <= (io.divisor == '0);
        end else if (state == CALC) begin
            shreg <= shreg_nxt;
            rem_w <= rem_nxt;
            cnt   <= cnt + CW'(1);
        end
    end

    // result registers change only on completion so the previous answer stays readable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_out   <= '0;
            r_out   <= '0;
            dbz_out <= 1'b0;
        end else if (last) begin
            if (zdiv) begin
                q_out   <= '1;
                r_out   <= '0;
                dbz_out <= 1'b1;
            end else begin
                q_out   <= shreg_nxt;
                r_out   <= rem_nxt;
                dbz_out <= 1'b0;
            end
        end
    end

    assign io.busy      = (state != IDLE);
    assign io.done      = (state == DONE);
    assign io.quotient  = q_out;
    assign io.remainder = r_out;
    assign io.dbz       = dbz_out;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboarded bench for seq_divider: directed scenarios followed by an exhaustive back-to-back sweep.
module tb_seq_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divider_if #(.DW(DW), .VW(VW)) dif();
    seq_divider #(.DW(DW), .VW(VW)) dut (.clk(clk), .rst_n(rst_n), .io(dif));

    typedef struct packed {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;

    function automatic logic [7:0] mul4x4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
            if (y[i]) acc = acc + ({4'b0000, x} << i);
        return acc;
    endfunction

    // drive a request, hold start until accepted; edges = edges to acceptance, 0 on timeout
    task automatic issue(input logic [7:0] a, input logic [3:0] b, output int edges);
        exp_t e;
        int ai, bi;
        ai = a; bi = b;
        e.a = a; e.b = b; e.z = (b == 4'h0);
        e.q = (bi == 0) ? 8'hFF : 8'(ai / bi);
        e.r = (bi == 0) ? 4'h0 : 4'(ai % bi);
        dif.dividend = a; dif.divisor = b; dif.start = 1'b1;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            edges++;
            if (dif.busy && !dif.done) break;
        end
        dif.start = 1'b0;
        if (dif.busy && !dif.done) sb.push_back(e);
        else edges = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (dif.done) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
        rst_n = 1'b0;
        #12;
        chk_cnt++; if (dif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", dif.busy); else pass_cnt++;
        chk_cnt++; if (dif.done !== 1'b0) $display("FAIL reset_done: got %b want 0", dif.done); else pass_cnt++;
        chk_cnt++; if (dif.quotient !== 8'h00) $display("FAIL reset_q: got %h want 00", dif.quotient); else pass_cnt++;
        chk_cnt++; if (dif.remainder !== 4'h0) $display("FAIL reset_r: got %h want 0", dif.remainder); else pass_cnt++;
        chk_cnt++; if (dif.dbz !== 1'b0) $display("FAIL reset_dbz: got %b want 0", dif.dbz); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int ed, n, busy_n;
        exp_t e;
        issue(8'hC8, 4'h7, ed);
        chk_cnt++; if (ed !== 1) $display("FAIL basic_accept: got %0d edges want 1", ed); else pass_cnt++;
        busy_n = dif.busy ? 1 : 0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (dif.busy) busy_n++;
            if (dif.done) begin n = i; break; end
        end
        chk_cnt++; if (n !== DW) $display("FAIL basic_latency: got %0d want %0d", n, DW); else pass_cnt++;
        if (sb.size() > 0) e = sb.pop_front(); else e = '0;
        chk_cnt++; if (dif.quotient !== e.q || e.q !== 8'h1C) $display("FAIL basic_q: got %h want 1c", dif.quotient); else pass_cnt++;
        chk_cnt++; if (dif.remainder !== e.r || e.r !== 4'h4) $display("FAIL basic_r: got %h want 4", dif.remainder); else pass_cnt++;
        chk_cnt++; if (dif.dbz !== 1'b0) $display("FAIL basic_dbz: got %b want 0", dif.dbz); else pass_cnt++;
        @(posedge clk); #1;
        if (dif.busy) busy_n++;
        chk_cnt++; if (dif.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", dif.done); else pass_cnt++;
        chk_cnt++; if (busy_n !== DW + 1) $display("FAIL basic_busy_cycles: got %0d want %0d", busy_n, DW + 1); else pass_cnt++;
    endtask

    task automatic test_edge_values();
        logic [7:0] ta [2];
        logic [3:0] tb [2];
        int ed, n;
        exp_t e;
        ta[0] = 8'hFF; tb[0] = 4'h1;
        ta[1] = 8'h05; tb[1] = 4'h9;
        for (int k = 0; k < 2; k++) begin
            issue(ta[k], tb[k], ed);
            chk_cnt++; if (ed == 0) $display("FAIL edge_accept[%0d]: got timeout want accept", k); else pass_cnt++;
            wait_done(n);
            chk_cnt++; if (n !== DW) $display("FAIL edge_latency[%0d]: got %0d want %0d", k, n, DW); else pass_cnt++;
            if (sb.size() > 0) e = sb.pop_front(); else e = '0;
            chk_cnt++; if (dif.quotient !== e.q) $display("FAIL edge_q[%0d]: got %h want %h", k, dif.quotient, e.q); else pass_cnt++;
            chk_cnt++; if (dif.remainder !== e.r) $display("FAIL edge_r[%0d]: got %h want %h", k, dif.remainder, e.r); else pass_cnt++;
        end
    endtask

    task automatic test_dbz();
        int ed, n;
        exp_t e;
        issue(8'h37, 4'h0, ed);
        wait_done(n);
        chk_cnt++; if (n !== 1) $display("FAIL dbz_latency: got %0d want 1", n); else pass_cnt++;
        if (sb.size() > 0) e = sb.pop_front(); else e = '0;
        chk_cnt++; if (dif.quotient !== e.q || e.q !== 8'hFF) $display("FAIL dbz_q: got %h want ff", dif.quotient); else pass_cnt++;
        chk_cnt++; if (dif.remainder !== 4'h0) $display("FAIL dbz_r: got %h want 0", dif.remainder); else pass_cnt++;
        chk_cnt++; if (dif.dbz !== 1'b1) $display("FAIL dbz_flag: got %b want 1", dif.dbz); else pass_cnt++;
        issue(8'h2A, 4'h5, ed);
        chk_cnt++; if (ed !== 2) $display("FAIL dbz_throughput: got %0d edges want 2", ed); else pass_cnt++;
        chk_cnt++; if (dif.dbz !== 1'b1) $display("FAIL dbz_held: got %b want 1", dif.dbz); else pass_cnt++;
        wait_done(n);
        if (sb.size() > 0) e = sb.pop_front(); else e = '0;
        chk_cnt++; if (dif.dbz !== 1'b0) $display("FAIL dbz_clear: got %b want 0", dif.dbz); else pass_cnt++;
        chk_cnt++; if (dif.quotient !== e.q || dif.remainder !== e.r) $display("FAIL dbz_next_result: got %h r %h want %h r %h", dif.quotient, dif.remainder, e.q, e.r); else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int ed, dones, done_at;
        logic [7:0] prev_q, res_q;
        logic [3:0] prev_r, res_r;
        exp_t e;
        prev_q = 8'h08; prev_r = 4'h2;
        @(posedge clk); #1;
        issue(8'h64, 4'h3, ed);
        chk_cnt++; if (ed !== 1) $display("FAIL ign_accept: got %0d edges want 1", ed); else pass_cnt++;
        dones = 0; done_at = 0; res_q = '0; res_r = '0;
        for (int i = 1; i <= DW + 6; i++) begin
            if (i == 3) begin dif.start = 1'b1; dif.dividend = 8'h10; dif.divisor = 4'h2; end
            @(posedge clk); #1;
            if (i == 3) dif.start = 1'b0;
            if (i == 5) begin
                chk_cnt++; if (dif.quotient !== prev_q || dif.remainder !== prev_r) $display("FAIL ign_held: got %h r %h want %h r %h", dif.quotient, dif.remainder, prev_q, prev_r); else pass_cnt++;
            end
            if (dif.done) begin
                dones++;
                if (done_at == 0) begin done_at = i; res_q = dif.quotient; res_r = dif.remainder; end
            end
        end
        chk_cnt++; if (dones !== 1) $display("FAIL ign_done_count: got %0d want 1", dones); else pass_cnt++;
        chk_cnt++; if (done_at !== DW) $display("FAIL ign_latency: got %0d want %0d", done_at, DW); else pass_cnt++;
        if (sb.size() > 0) e = sb.pop_front(); else e = '0;
        chk_cnt++; if (res_q !== e.q || res_q !== 8'h21) $display("FAIL ign_q: got %h want 21", res_q); else pass_cnt++;
        chk_cnt++; if (res_r !== e.r || res_r !== 4'h1) $display("FAIL ign_r: got %h want 1", res_r); else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        int ed, n, dones;
        exp_t e;
        issue(8'hF0, 4'hB, ed);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (dif.quotient !== 8'h00 || dif.remainder !== 4'h0) $display("FAIL rst_outputs: got %h r %h want 00 r 0", dif.quotient, dif.remainder); else pass_cnt++;
        chk_cnt++; if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.dbz !== 1'b0) $display("FAIL rst_flags: got busy %b done %b dbz %b want 0 0 0", dif.busy, dif.done, dif.dbz); else pass_cnt++;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (dif.done || dif.busy) dones++;
        end
        chk_cnt++; if (dones !== 0) $display("FAIL rst_no_done: got %0d active cycles want 0", dones); else pass_cnt++;
        issue(8'hF0, 4'hB, ed);
        wait_done(n);
        chk_cnt++; if (n !== DW) $display("FAIL rst_redo_latency: got %0d want %0d", n, DW); else pass_cnt++;
        if (sb.size() > 0) e = sb.pop_front(); else e = '0;
        chk_cnt++; if (dif.quotient !== e.q || e.q !== 8'h15) $display("FAIL rst_redo_q: got %h want 15", dif.quotient); else pass_cnt++;
        chk_cnt++; if (dif.remainder !== e.r || e.r !== 4'h9) $display("FAIL rst_redo_r: got %h want 9", dif.remainder); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ed, n, prod;
        exp_t e;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(8'(a), 4'(b), ed);
                chk_cnt++; if (ed !== 2) $display("FAIL b2b_interval %0d/%0d: got %0d edges want 2", a, b, ed); else pass_cnt++;
                wait_done(n);
                chk_cnt++; if (n !== ((b == 0) ? 1 : DW)) $display("FAIL b2b_latency %0d/%0d: got %0d", a, b, n); else pass_cnt++;
                if (sb.size() > 0) e = sb.pop_front(); else e = '0;
                chk_cnt++;
                if (dif.quotient !== e.q || dif.remainder !== e.r || dif.dbz !== e.z)
                    $display("FAIL b2b_result %0d/%0d: got %h r %h z %b want %h r %h z %b", a, b, dif.quotient, dif.remainder, dif.dbz, e.q, e.r, e.z);
                else pass_cnt++;
                if (b != 0) begin
                    if (dif.quotient < 8'd16) prod = int'(mul4x4(dif.quotient[3:0], 4'(b)));
                    else prod = int'(dif.quotient) * b;
                    chk_cnt++;
                    if (prod + int'(dif.remainder) != a || int'(dif.remainder) >= b)
                        $display("FAIL b2b_invariant %0d/%0d: got q %h r %h want q*d+r=%0d and r<d", a, b, dif.quotient, dif.remainder, a);
                    else pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_values();
        test_dbz();
        test_ignore_start();
        test_reset_mid_calc();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
